charmatrix_scan: RTL

Display-side stage directly downstream of the character ROM. It accepts 8-bit character codes over a valid/ready handshake and drives the ROM address. At frame boundaries it captures the 35-bit 5x7 bitmap the ROM returns, then time-multiplexes that bitmap onto a 7-row x 5-column LED matrix. Blanking gaps between rows prevent ghosting. Sits between the serial receive path (upstream) and the matrix pins (downstream).

---
 rtl/charmatrix_pkg.sv | 19 +
 rtl/charmatrix_glyph_latch.sv | 54 +++++
 rtl/charmatrix_scan.sv | 132 +++++++++++++
 3 files changed

// File: rtl/charmatrix_pkg.sv
// Shared constants, scan-state encoding and glyph row-slice helper for the
// 5x7 character matrix scanner.
package charmatrix_pkg;

  localparam int N_ROWS     = 7;
  localparam int N_COLS     = 5;
  localparam int GLYPH_BITS = N_ROWS * N_COLS;

  typedef enum logic {
    BLANK = 1'b0,
    ROW   = 1'b1
  } scan_state_e;

  // Row 0 occupies the top five bits of the glyph; MSB of each slice is the leftmost column.
  function automatic int row_msb(input int r);
    return GLYPH_BITS - 1 - N_COLS * r;
  endfunction

endpackage

// File: rtl/charmatrix_glyph_latch.sv
// Character handshake, ROM address register and displayed-bitmap register.
// A code is held pending until the scanner signals a frame boundary.
module charmatrix_glyph_latch
  import charmatrix_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            char_code_i,
  input  logic                  char_valid_i,
  output logic                  char_ready_o,
  input  logic                  boundary_i,
  output logic [7:0]            rom_addr_o,
  input  logic [GLYPH_BITS-1:0] rom_data_i,
  output logic [GLYPH_BITS-1:0] bitmap_o
);

  logic                  pending_q, pending_d;
  logic [7:0]            rom_addr_q, rom_addr_d;
  logic [GLYPH_BITS-1:0] bitmap_q, bitmap_d;

  // Accept needs pending=0 and load needs pending=1, so a code accepted on a
  // boundary edge waits for the following boundary.
  always_comb begin
    pending_d  = pending_q;
    rom_addr_d = rom_addr_q;
    bitmap_d   = bitmap_q;
    if (pending_q) begin
      if (boundary_i) begin
        bitmap_d  = rom_data_i;
        pending_d = 1'b0;
      end
    end else if (char_valid_i) begin
      rom_addr_d = char_code_i;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= 1'b0;
      rom_addr_q <= 8'h00;
      bitmap_q   <= '0;
    end else begin
      pending_q  <= pending_d;
      rom_addr_q <= rom_addr_d;
      bitmap_q   <= bitmap_d;
    end
  end

  assign char_ready_o = ~pending_q;
  assign rom_addr_o   = rom_addr_q;
  assign bitmap_o     = bitmap_q;

endmodule

// File: rtl/charmatrix_scan.sv
// 7x5 LED matrix scanner: alternates blanking and lit phases per row, and
// swaps in a new glyph from the character ROM only at frame boundaries.
module charmatrix_scan
  import charmatrix_pkg::*;
#(
  parameter int ROW_CYCLES     = 1024,
  parameter int BLANK_CYCLES   = 16,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [7:0]            char_code,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic [7:0]            rom_addr,
  input  logic [GLYPH_BITS-1:0] rom_data,
  output logic [N_ROWS-1:0]     row_out,
  output logic [N_COLS-1:0]     col_out
);

  localparam int MAX_CYC = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  ROW_LAST   = CNT_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]        LAST_ROW   = 3'(N_ROWS - 1);
  localparam logic [N_ROWS-1:0] ROW_IDLE   = {N_ROWS{ROW_ACTIVE_LOW}};
  localparam logic [N_COLS-1:0] COL_IDLE   = {N_COLS{COL_ACTIVE_LOW}};

  scan_state_e           state_q, state_d;
  logic [2:0]            row_idx_q, row_idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_ROWS-1:0]     row_out_q, row_out_d;
  logic [N_COLS-1:0]     col_out_q, col_out_d;
  logic                  boundary;
  logic [GLYPH_BITS-1:0] bitmap;
  logic [N_COLS-1:0]     glyph_rows [N_ROWS];
  logic [N_ROWS-1:0]     row_lit;
  logic [N_COLS-1:0]     col_lit;

  charmatrix_glyph_latch u_latch (
    .clk          (clk),
    .rst_n        (rst_n),
    .char_code_i  (char_code),
    .char_valid_i (char_valid),
    .char_ready_o (char_ready),
    .boundary_i   (boundary),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .bitmap_o     (bitmap)
  );

  always_comb begin
    for (int r = 0; r < N_ROWS; r++) begin
      glyph_rows[r] = bitmap[row_msb(r) -: N_COLS];
    end
  end

  // While disabled every edge counts as a boundary so a pending glyph lands at once.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    boundary  = 1'b0;
    if (!enable) begin
      state_d   = BLANK;
      row_idx_d = '0;
      cnt_d     = '0;
      boundary  = 1'b1;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ROW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ROW: begin
          if (cnt_q == ROW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (row_idx_q == LAST_ROW) begin
              row_idx_d = '0;
              boundary  = 1'b1;
            end else begin
              row_idx_d = row_idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Outputs are registered from next state; the bitmap only changes on edges
  // that enter BLANK, so the current bitmap is the one shown in state_d.
  always_comb begin
    row_lit = '0;
    col_lit = '0;
    if (state_d == ROW) begin
      row_lit[row_idx_d] = 1'b1;
      col_lit            = glyph_rows[row_idx_d];
    end
    row_out_d = row_lit ^ ROW_IDLE;
    col_out_d = col_lit ^ COL_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      row_idx_q <= '0;
      cnt_q     <= '0;
      row_out_q <= ROW_IDLE;
      col_out_q <= COL_IDLE;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      row_out_q <= row_out_d;
      col_out_q <= col_out_d;
    end
  end

  assign row_out = row_out_q;
  assign col_out = col_out_q;

endmodule
